// File: rtl/input_capture_pio.sv
// Avalon-MM input PIO: synchronised, debounced pushbuttons and switches with edge capture, IRQ and key[0] press counter.
// Optional build macro INPUT_CAPTURE_SW_EDGE_EN lets switch changes capture edges and raise the interrupt.
module input_capture_pio #(
    parameter int KEY_W       = 1,
    parameter int SW_W        = 10,
    parameter int TICK_CYCLES = 250000,
    parameter int DB_SAMPLES  = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           address,
    input  logic                 chipselect,
    input  logic                 read,
    input  logic                 write,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    output logic                 irq,
    input  logic [KEY_W-1:0]     key_in,
    input  logic [SW_W-1:0]      sw_in
);

    localparam int N  = KEY_W + SW_W;
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [N-1:0] IDLE_LEVEL = {{SW_W{1'b0}}, {KEY_W{1'b1}}};
`ifdef INPUT_CAPTURE_SW_EDGE_EN
    localparam logic [N-1:0] EDGE_MASK = {N{1'b1}};
`else
    localparam logic [N-1:0] EDGE_MASK = {{SW_W{1'b0}}, {KEY_W{1'b1}}};
`endif

    logic [N-1:0]        meta_r;
    logic [N-1:0]        sync_r;
    logic [N-1:0]        db_r;
    logic [N-1:0]        db_nxt_s;
    logic [N-1:0][2:0]   cnt_r;
    logic [N-1:0][2:0]   cnt_nxt_s;
    logic                primed_r;
    logic                primed_nxt_s;
    logic [PW-1:0]       presc_r;
    logic                tick_s;
    logic [N-1:0]        changed_s;
    logic [N-1:0]        new_edge_s;
    logic                press_s;
    logic [N-1:0]        irqmask_r;
    logic [N-1:0]        edgecap_r;
    logic [N-1:0]        edgecap_nxt_s;
    logic [15:0]         presses_r;
    logic                wr_s;
    logic                rd_s;
    logic                unused_wdata_s;

    assign wr_s           = chipselect & write;
    assign rd_s           = chipselect & read;
    assign tick_s         = (presc_r == PW'(TICK_CYCLES - 1));
    assign unused_wdata_s = ^writedata[31:N];

    // Two-flop synchroniser; idle levels match released keys and low switches.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_r <= IDLE_LEVEL;
            sync_r <= IDLE_LEVEL;
        end else begin
            meta_r <= {sw_in, key_in};
            sync_r <= meta_r;
        end
    end

    // Debounce sample prescaler, wrapping at TICK_CYCLES-1.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc_r <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // Per-bit debounce; the first tick after reset just adopts the synced levels.
    always_comb begin
        db_nxt_s     = db_r;
        cnt_nxt_s    = cnt_r;
        primed_nxt_s = primed_r;
        if (tick_s) begin
            if (!primed_r) begin
                db_nxt_s     = sync_r;
                cnt_nxt_s    = '0;
                primed_nxt_s = 1'b1;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (sync_r[i] == db_r[i]) begin
                        cnt_nxt_s[i] = 3'd0;
                    end else if (cnt_r[i] == 3'(DB_SAMPLES - 1)) begin
                        db_nxt_s[i]  = sync_r[i];
                        cnt_nxt_s[i] = 3'd0;
                    end else begin
                        cnt_nxt_s[i] = cnt_r[i] + 3'd1;
                    end
                end
            end
        end else begin
            primed_nxt_s = primed_r;
        end
    end

    // Keys capture only presses (1->0); switches capture any change.
    always_comb begin
        changed_s  = primed_r ? (db_r ^ db_nxt_s) : '0;
        new_edge_s = {changed_s[N-1:KEY_W], changed_s[KEY_W-1:0] & db_r[KEY_W-1:0]} & EDGE_MASK;
        press_s    = changed_s[0] & db_r[0];
        if (wr_s && (address == 2'd2)) begin
            edgecap_nxt_s = ((edgecap_r & ~writedata[N-1:0]) | new_edge_s) & EDGE_MASK;
        end else begin
            edgecap_nxt_s = (edgecap_r | new_edge_s) & EDGE_MASK;
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            db_r     <= IDLE_LEVEL;
            cnt_r    <= '0;
            primed_r <= 1'b0;
        end else begin
            db_r     <= db_nxt_s;
            cnt_r    <= cnt_nxt_s;
            primed_r <= primed_nxt_s;
        end
    end

    // Software-visible registers; a same-cycle press beats a clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irqmask_r <= '0;
            edgecap_r <= '0;
            presses_r <= 16'h0000;
        end else begin
            edgecap_r <= edgecap_nxt_s;
            if (wr_s && (address == 2'd1)) begin
                irqmask_r <= writedata[N-1:0] & EDGE_MASK;
            end else begin
                irqmask_r <= irqmask_r;
            end
            if (wr_s && (address == 2'd3)) begin
                presses_r <= {15'h0000, press_s};
            end else if (press_s) begin
                presses_r <= presses_r + 16'h0001;
            end else begin
                presses_r <= presses_r;
            end
        end
    end

    // Registered read port and level interrupt.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            readdata <= 32'h0000_0000;
            irq      <= 1'b0;
        end else begin
            irq <= |(edgecap_r & irqmask_r);
            if (rd_s) begin
                case (address)
                    2'd0:    readdata <= 32'(db_r);
                    2'd1:    readdata <= 32'(irqmask_r);
                    2'd2:    readdata <= 32'(edgecap_r);
                    2'd3:    readdata <= {16'h0000, presses_r};
                    default: readdata <= 32'h0000_0000;
                endcase
            end else begin
                readdata <= readdata;
            end
        end
    end

endmodule

// File: tb/tb_input_capture_pio.sv
// Bench for input_capture_pio: directed scenarios plus randomized pin and bus traffic against a cycle-level behavioural model.
module tb_input_capture_pio;

    localparam int KW = 1;
    localparam int SW = 10;
    localparam int T  = 4;
    localparam int DB = 3;
    localparam int N  = KW + SW;
`ifdef INPUT_CAPTURE_SW_EDGE_EN
    localparam bit [N-1:0] SWE = {N{1'b1}};
`else
    localparam bit [N-1:0] SWE = {{SW{1'b0}}, {KW{1'b1}}};
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    address = 2'd0;
    logic          chipselect = 1'b0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [31:0]   writedata = 32'h0;
    logic [31:0]   readdata;
    logic          irq;
    logic [KW-1:0] key_in = '1;
    logic [SW-1:0] sw_in = '0;

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    bit [N-1:0] m_h0, m_h1, m_db, m_mask, m_ecap;
    int         m_run [N];
    int         m_k;
    bit         m_primed;
    int         m_presses;
    bit [31:0]  m_rd;
    bit         m_irq;

    input_capture_pio #(.KEY_W(KW), .SW_W(SW), .TICK_CYCLES(T), .DB_SAMPLES(DB)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read(read), .write(write), .writedata(writedata), .readdata(readdata),
        .irq(irq), .key_in(key_in), .sw_in(sw_in)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_h0 = {{SW{1'b0}}, {KW{1'b1}}};
        m_h1 = m_h0;
        m_db = m_h0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
        m_k = 0; m_primed = 0; m_mask = '0; m_ecap = '0;
        m_presses = 0; m_rd = 32'h0; m_irq = 0;
    endtask

    // One clock edge of the reference behaviour, using the pins/bus held during that edge.
    task automatic model_step();
        bit [N-1:0] synced, old_db, old_ecap, old_mask, edges;
        int old_presses;
        bit press;
        if (!reset_n) begin
            model_reset();
            return;
        end
        synced = m_h1; old_db = m_db; old_ecap = m_ecap; old_mask = m_mask;
        old_presses = m_presses; edges = '0; press = 0;
        if ((m_k % T) == T - 1) begin
            if (!m_primed) begin
                m_db = synced;
                m_primed = 1;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (synced[i] == m_db[i]) m_run[i] = 0;
                    else begin
                        m_run[i]++;
                        if (m_run[i] == DB) begin
                            m_db[i] = synced[i];
                            m_run[i] = 0;
                            if (i >= KW) edges[i] = 1;
                            else if (!synced[i]) begin
                                edges[i] = 1;
                                if (i == 0) press = 1;
                            end
                        end
                    end
                end
            end
        end
        edges &= SWE;
        if (chipselect && read) begin
            case (address)
                2'd0: m_rd = 32'(old_db);
                2'd1: m_rd = 32'(old_mask);
                2'd2: m_rd = 32'(old_ecap);
                default: m_rd = 32'(old_presses);
            endcase
        end
        m_irq = |(old_ecap & old_mask);
        if (chipselect && write && address == 2'd2) m_ecap = old_ecap & ~writedata[N-1:0];
        m_ecap |= edges;
        if (chipselect && write && address == 2'd1) m_mask = writedata[N-1:0] & SWE;
        if (chipselect && write && address == 2'd3) m_presses = press ? 1 : 0;
        else m_presses = (old_presses + (press ? 1 : 0)) % 65536;
        m_h1 = m_h0;
        m_h0 = {sw_in, key_in};
        m_k++;
    endtask

    function automatic bit will_press();
        return ((m_k % T) == T - 1) && m_primed && m_db[0] && !m_h1[0] && (m_run[0] == DB - 1);
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_val("readdata", readdata, m_rd);
        check_val("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        chipselect = 1; read = 1; address = a;
        cycle();
        chipselect = 0; read = 0;
        d = readdata;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1; write = 1; address = a; writedata = d;
        cycle();
        chipselect = 0; write = 0;
    endtask

    task automatic wait_press_edge(input string tag);
        int cnt = 0;
        while (!will_press() && cnt < 100) begin
            cycle();
            cnt++;
        end
        if (cnt >= 100) check_val({tag, "_timeout"}, 32'(cnt), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        int key_hold = 0, sw_hold = 0, r;

        // 1: reset state, idle inputs
        reset_n = 0; key_in = '1; sw_in = 10'h2A5;
        idle(2);
        check_val("reset_readdata", readdata, 32'h0);
        check_val("reset_irq", 32'(irq), 32'h0);
        reset_n = 1;
        idle(12);
        bus_read(2'd0, d); check_val("data_idle", d, 32'h54B);
        bus_read(2'd2, d); check_val("ecap_idle", d, 32'h0);
        check_val("irq_idle", 32'(irq), 32'h0);

        // 2: press, irq on mask, W1C clears irq
        key_in = '0;
        idle(20);
        bus_read(2'd0, d); check_val("data_pressed", d, 32'h54A);
        bus_read(2'd2, d); check_val("ecap_press", d, 32'h1);
        bus_write(2'd1, 32'h1);
        cycle();
        check_val("irq_set", 32'(irq), 32'h1);
        bus_write(2'd2, 32'h1);
        cycle();
        check_val("irq_clr", 32'(irq), 32'h0);

        // 3: short glitch is filtered
        key_in = '1; idle(20);
        bus_write(2'd3, 32'h0);
        key_in = '0; idle(8);
        key_in = '1; idle(20);
        bus_read(2'd0, d); check_val("glitch_data0", d & 32'h1, 32'h1);
        bus_read(2'd2, d); check_val("glitch_ecap", d, 32'h0);
        bus_read(2'd3, d); check_val("glitch_presses", d, 32'h0);

        // 4: W1C colliding with a new press
        key_in = '0; idle(20);
        key_in = '1; idle(20);
        check_val("irq_before_collide", 32'(irq), 32'h1);
        key_in = '0;
        wait_press_edge("ecap_collide");
        bus_write(2'd2, 32'h1);
        bus_read(2'd2, d); check_val("ecap_collide", d, 32'h1);
        check_val("irq_collide", 32'(irq), 32'h1);

        // 5: presses counting and clear colliding with a press
        key_in = '1; idle(20);
        bus_read(2'd3, d); check_val("presses_two", d, 32'h2);
        key_in = '0;
        wait_press_edge("presses_collide");
        bus_write(2'd3, $urandom);
        bus_read(2'd3, d); check_val("presses_collide", d, 32'h1);

        // 6: switch edge capture
        key_in = '1; idle(20);
        bus_write(2'd1, 32'h7FF);
        bus_write(2'd2, 32'h7FF);
        idle(2);
        sw_in = 10'h2AD; idle(20);
        bus_read(2'd2, d);
`ifdef INPUT_CAPTURE_SW_EDGE_EN
        check_val("sw_ecap", d, 32'h10);
        check_val("sw_irq", 32'(irq), 32'h1);
`else
        check_val("sw_ecap", d, 32'h0);
        check_val("sw_irq", 32'(irq), 32'h0);
        bus_read(2'd1, d); check_val("sw_mask", d, 32'h1);
`endif

        // randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            if (key_hold == 0) begin
                key_in = KW'($urandom_range(0, 1));
                key_hold = $urandom_range(1, 24);
            end else key_hold--;
            if (sw_hold == 0) begin
                sw_in = sw_in ^ (SW'(1) << $urandom_range(0, SW - 1));
                sw_hold = $urandom_range(1, 40);
            end else sw_hold--;
            chipselect = 0; read = 0; write = 0;
            r = $urandom_range(0, 99);
            address = 2'($urandom_range(0, 3));
            writedata = $urandom;
            if (r < 15) begin
                chipselect = 1; read = 1;
            end else if (r < 22) begin
                chipselect = 1; write = 1;
            end
            reset_n = ($urandom_range(0, 599) != 0);
            cycle();
        end
        chipselect = 0; read = 0; write = 0; reset_n = 1;
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
